lbp_host_mem_responder: RTL and testbench
=========================================

// Module: lbp_host_mem_responder
// PURPOSE
//  Host-side responder for the LBP engine's gray-image read / LBP-result write interface.
//  Holds the 128x128 gray image and serves it over gray_addr/gray_data, gated by gray_ready.
//  Captures lbp_valid writes into a result memory and tracks the engine's finish.
//  Exposes the results on a readback port.
//  Sits between the LBP engine and the system loader/checker; also used as the bench host.
// PARAMETERS
//  ADDR_WIDTH  14     pixel address width, {row[6:0],col[6:0]}
//  DATA_WIDTH  8      pixel / LBP code width
//  IMG_WIDTH   128    image side length; depth = IMG_WIDTH*IMG_WIDTH
//  LFSR_SEED   8'hA5  throttle LFSR reset value (used only with READY_THROTTLE_EN)
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-low reset
//  img_we         in   1   image load write strobe (LOAD state only)
//  img_waddr      in   14  image load address
//  img_wdata      in   8   image load data
//  img_load_done  in   1   loader pulse: image complete, start serving
//  gray_addr      in   14  engine pixel address
//  gray_req       in   1   engine request qualifier (counted only, not required for data)
//  gray_ready     out  1   image available to engine
//  gray_data      out  8   pixel at gray_addr
//  lbp_addr       in   14  engine result address
//  lbp_valid      in   1   engine result write strobe
//  lbp_data       in   8   engine LBP code
//  finish         in   1   engine completion level
//  res_raddr      in   14  result readback address
//  res_rdata      out  8   result readback data, registered
//  wr_count       out  15  accepted LBP writes since reset
//  req_count      out  15  cycles with gray_req && gray_ready
//  late_wr        out  1   sticky: lbp_valid seen in DONE
//  done           out  1   finish accepted
// BEHAVIOUR
//  States: LOAD(0) -> SERVE(1) -> DONE(2).
//   - LOAD->SERVE: cycle after img_load_done is sampled high.
//   - SERVE->DONE: cycle after finish is sampled high.
//   - DONE holds until reset. Encoding 3 -> LOAD.
//  Reset (reset==0 at posedge), also mid-operation:
//   - state=LOAD; gray_ready=0, res_rdata=0, wr_count=0, req_count=0, late_wr=0, done=0.
//   - Image and result memories are NOT cleared.
//  LOAD:
//   - img_we writes img_mem[img_waddr]<=img_wdata at the edge.
//   - img_we together with img_load_done: the write completes, then the state goes to SERVE.
//   - lbp_valid, finish and gray_req are ignored.
//  SERVE:
//   - gray_ready=1, subject to the optional throttle below.
//   - gray_data = img_mem[gray_addr], combinational, zero latency, valid whenever gray_ready=1.
//     The engine latches the center pixel without gray_req, so gray_req must not gate data.
//   - gray_ready=0 -> gray_data=0.
//   - img_we is ignored.
//   - lbp_valid=1 at an edge: res_mem[lbp_addr]<=lbp_data; wr_count+1 (saturates at 15'h7FFF).
//   - gray_req && gray_ready: req_count+1 (saturating).
//   - Same-cycle finish and lbp_valid: the write is accepted, then DONE.
//   - Never-written result addresses (image border) keep their prior contents.
//  DONE:
//   - done=1, gray_ready=0.
//   - lbp_valid is not written to memory and sets late_wr.
//  Readback:
//   - res_rdata<=res_mem[res_raddr] every cycle in any state; 1-cycle latency.
//   - Reading the address written in the same cycle returns the old data (read-before-write).
//  Widths: 14-bit addresses index the full 16384 depth (no out-of-range case); counters 15 bits.
// CONFIGURATION
//  READY_THROTTLE_EN defined:
//   - 8-bit Fibonacci LFSR, taps 8,6,5,4; loaded with LFSR_SEED on reset; advances every SERVE cycle.
//   - gray_ready = (state==SERVE) && (lfsr[1:0]!=2'b00).
//   - Stresses the engine's ready-gated counter.
//  READY_THROTTLE_EN undefined:
//   - No LFSR; gray_ready = (state==SERVE).
// TESTING
//  1. Load img_mem[a]=a[7:0], pulse img_load_done -> gray_ready=1 next cycle.
//     gray_addr=14'h0081 -> gray_data=8'h81 in the same cycle.
//  2. SERVE: lbp_valid with lbp_addr=14'h0081, lbp_data=8'hD6; then res_raddr=14'h0081
//     -> res_rdata=8'hD6 one cycle later; wr_count=1.
//  3. Connect the LBP engine on a flat image (all 8'h40) -> 126*126=15876 writes, all 8'hFF.
//     finish -> done=1 next cycle; wr_count=15876; late_wr=0.
//  4. In DONE, pulse lbp_valid (addr 14'h0000, data 8'h55) -> res_mem[0] unchanged; late_wr=1.
//  5. Mid-SERVE reset low 1 cycle -> state LOAD, gray_ready=0, counters 0.
//     Image still readable after a new img_load_done.
//  6. With READY_THROTTLE_EN: gray_ready low exactly when lfsr[1:0]==0 (seed 8'hA5 sequence).
//     Engine output is identical to case 3.

Source files
------------

// File: rtl/lbp_host_mem_responder.sv
// ---------------------------------------------------------------------------
// lbp_host_mem_responder
//
// Purpose:
//   Host-side memory responder for the LBP engine. It holds the 128x128 gray
//   image, serves pixels to the engine over a zero-latency combinational read
//   port, captures the engine's LBP result writes into a result memory, and
//   exposes those results on a registered readback port.
//   Lifecycle: LOAD (image filled by the loader) -> SERVE (engine running)
//   -> DONE (engine reported finish). DONE is held until reset.
//
// Configuration macro:
//   READY_THROTTLE_EN - when defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4)
//                       randomly withholds gray_ready during SERVE so that the
//                       engine's ready-gated logic gets exercised.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-low reset
//   img_we         in   image load write strobe (honoured in LOAD only)
//   img_waddr      in   image load address {row,col}
//   img_wdata      in   image load data
//   img_load_done  in   loader pulse: image complete, begin serving
//   gray_addr      in   engine pixel address
//   gray_req       in   engine request qualifier (only counted)
//   gray_ready     out  image available to the engine
//   gray_data      out  pixel at gray_addr (0 while not ready)
//   lbp_addr       in   engine result address
//   lbp_valid      in   engine result write strobe
//   lbp_data       in   engine LBP code
//   finish         in   engine completion level
//   res_raddr      in   result readback address
//   res_rdata      out  result readback data, one cycle latency
//   wr_count       out  accepted result writes since reset (saturating)
//   req_count      out  cycles with gray_req && gray_ready (saturating)
//   late_wr        out  sticky flag: result write attempted after finish
//   done           out  finish has been accepted
// ---------------------------------------------------------------------------
module lbp_host_mem_responder #(
   parameter int         ADDR_WIDTH = 14,
   parameter int         DATA_WIDTH = 8,
   parameter int         IMG_WIDTH  = 128,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  img_we,
   input  logic [ADDR_WIDTH-1:0] img_waddr,
   input  logic [DATA_WIDTH-1:0] img_wdata,
   input  logic                  img_load_done,
   input  logic [ADDR_WIDTH-1:0] gray_addr,
   input  logic                  gray_req,
   output logic                  gray_ready,
   output logic [DATA_WIDTH-1:0] gray_data,
   input  logic [ADDR_WIDTH-1:0] lbp_addr,
   input  logic                  lbp_valid,
   input  logic [DATA_WIDTH-1:0] lbp_data,
   input  logic                  finish,
   input  logic [ADDR_WIDTH-1:0] res_raddr,
   output logic [DATA_WIDTH-1:0] res_rdata,
   output logic [14:0]           wr_count,
   output logic [14:0]           req_count,
   output logic                  late_wr,
   output logic                  done
);

   localparam int DEPTH = IMG_WIDTH * IMG_WIDTH;
   localparam logic [14:0] COUNT_MAX = 15'h7FFF;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [DATA_WIDTH-1:0] img_mem [DEPTH];
   logic [DATA_WIDTH-1:0] res_mem [DEPTH];

   logic serving;
   logic throttle_ok;
   logic res_write;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_LOAD;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; the unused encoding falls back to LOAD
   always_comb begin
      next_state = ST_LOAD;
      serving    = 1'b0;
      done       = 1'b0;
      case (state)
         ST_LOAD: begin
            next_state = img_load_done ? ST_SERVE : ST_LOAD;
         end
         ST_SERVE: begin
            serving    = 1'b1;
            next_state = finish ? ST_DONE : ST_SERVE;
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_DONE;
         end
         default: begin
            next_state = ST_LOAD;
         end
      endcase
   end

`ifdef READY_THROTTLE_EN
   // Throttle LFSR: steps only while serving so the ready pattern is
   // reproducible from the seed regardless of how long LOAD lasted.
   logic [7:0] lfsr;
   logic       lfsr_fb;

   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr <= LFSR_SEED;
      end else if (serving) begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end

   assign throttle_ok = (lfsr[1:0] != 2'b00);
`else
   logic [7:0] unused_seed;
   assign unused_seed = LFSR_SEED;
   assign throttle_ok = 1'b1;
`endif

   assign gray_ready = serving && throttle_ok;

   // Data must not depend on gray_req: the engine latches the centre pixel
   // without asserting it.
   assign gray_data = gray_ready ? img_mem[gray_addr] : '0;

   assign res_write = serving && lbp_valid;

   // Image memory: written by the loader only before serving starts
   always_ff @(posedge clk) begin
      if (reset && (state == ST_LOAD) && img_we) begin
         img_mem[img_waddr] <= img_wdata;
      end
   end

   // Result memory: contents survive reset; unwritten border cells keep
   // whatever they held before
   always_ff @(posedge clk) begin
      if (reset && res_write) begin
         res_mem[lbp_addr] <= lbp_data;
      end
   end

   // Registered readback; a same-cycle write is not visible (read-before-write)
   always_ff @(posedge clk) begin
      if (!reset) begin
         res_rdata <= '0;
      end else begin
         res_rdata <= res_mem[res_raddr];
      end
   end

   // Saturating activity counters and the late-write flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_count  <= '0;
         req_count <= '0;
         late_wr   <= 1'b0;
      end else begin
         if (res_write && (wr_count != COUNT_MAX)) begin
            wr_count <= wr_count + 15'd1;
         end
         if (gray_req && gray_ready && (req_count != COUNT_MAX)) begin
            req_count <= req_count + 15'd1;
         end
         if ((state == ST_DONE) && lbp_valid) begin
            late_wr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lbp_host_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lbp_host_mem_responder
//
// Purpose:
//   Self-checking bench for lbp_host_mem_responder. A behavioural model of
//   the host memories, phase and counters is updated on every rising edge
//   from the same inputs the DUT sees; a compare process checks all outputs
//   against that model on every falling edge. A few hand-computed literal
//   checks pin the model down at known points of the run.
// ---------------------------------------------------------------------------
module tb_lbp_host_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        img_we;
   logic [13:0] img_waddr;
   logic [7:0]  img_wdata;
   logic        img_load_done;
   logic [13:0] gray_addr;
   logic        gray_req;
   logic        gray_ready;
   logic [7:0]  gray_data;
   logic [13:0] lbp_addr;
   logic        lbp_valid;
   logic [7:0]  lbp_data;
   logic        finish;
   logic [13:0] res_raddr;
   logic [7:0]  res_rdata;
   logic [14:0] wr_count;
   logic [14:0] req_count;
   logic        late_wr;
   logic        done;

   always #5 clk = ~clk;

   lbp_host_mem_responder dut (
      .clk           (clk),
      .reset         (reset),
      .img_we        (img_we),
      .img_waddr     (img_waddr),
      .img_wdata     (img_wdata),
      .img_load_done (img_load_done),
      .gray_addr     (gray_addr),
      .gray_req      (gray_req),
      .gray_ready    (gray_ready),
      .gray_data     (gray_data),
      .lbp_addr      (lbp_addr),
      .lbp_valid     (lbp_valid),
      .lbp_data      (lbp_data),
      .finish        (finish),
      .res_raddr     (res_raddr),
      .res_rdata     (res_rdata),
      .wr_count      (wr_count),
      .req_count     (req_count),
      .late_wr       (late_wr),
      .done          (done)
   );

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: what the host should be holding and reporting
   localparam int PH_LOAD  = 0;
   localparam int PH_SERVE = 1;
   localparam int PH_DONE  = 2;

   logic [7:0] m_img [16384];
   logic [7:0] m_res [16384];
   bit         m_res_known [16384];
   int         m_phase = PH_LOAD;
   int         m_wr = 0;
   int         m_req = 0;
   bit         m_late = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   bit         m_rdata_known = 1'b0;
   logic [7:0] m_lfsr = 8'hA5;
   bit         m_rdy;

   function automatic bit model_ready();
      bit r;
      r = (m_phase == PH_SERVE);
`ifdef READY_THROTTLE_EN
      if (m_lfsr[1:0] == 2'b00) r = 1'b0;
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_phase       = PH_LOAD;
         m_wr          = 0;
         m_req         = 0;
         m_late        = 1'b0;
         m_rdata       = 8'h00;
         m_rdata_known = 1'b1;
         m_lfsr        = 8'hA5;
      end else begin
         if (m_res_known[res_raddr]) begin
            m_rdata       = m_res[res_raddr];
            m_rdata_known = 1'b1;
         end else begin
            m_rdata_known = 1'b0;
         end
         if (m_phase == PH_LOAD) begin
            if (img_we) m_img[img_waddr] = img_wdata;
            if (img_load_done) m_phase = PH_SERVE;
         end else if (m_phase == PH_SERVE) begin
            if (gray_req && model_ready() && m_req < 32767) m_req++;
            if (lbp_valid) begin
               m_res[lbp_addr]       = lbp_data;
               m_res_known[lbp_addr] = 1'b1;
               if (m_wr < 32767) m_wr++;
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (finish) m_phase = PH_DONE;
         end else begin
            if (lbp_valid) m_late = 1'b1;
         end
      end
   end

   // Compare process: every output against the model, away from the edge
   always @(negedge clk) begin
      if (check_en) begin
         m_rdy = model_ready();
         checkOutput("gray_ready", {31'b0, gray_ready}, {31'b0, m_rdy});
         checkOutput("gray_data", {24'b0, gray_data},
                     m_rdy ? {24'b0, m_img[gray_addr]} : 32'h0);
         checkOutput("wr_count", {17'b0, wr_count}, m_wr);
         checkOutput("req_count", {17'b0, req_count}, m_req);
         checkOutput("late_wr", {31'b0, late_wr}, {31'b0, m_late});
         checkOutput("done", {31'b0, done}, (m_phase == PH_DONE) ? 32'h1 : 32'h0);
         if (m_rdata_known) checkOutput("res_rdata", {24'b0, res_rdata}, {24'b0, m_rdata});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of random traffic on every engine/readback/loader input
   task automatic applyStimulus(input logic [13:0] last_addr);
      int sel;
      gray_addr = 14'($urandom);
      gray_req  = 1'($urandom);
      lbp_valid = 1'($urandom);
      lbp_addr  = 14'($urandom_range(1, 16383));
      lbp_data  = 8'($urandom);
      img_we    = 1'($urandom);
      img_waddr = 14'($urandom);
      img_wdata = 8'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
         0: res_raddr = 14'h0081;
         1: res_raddr = 14'h0000;
         2: res_raddr = last_addr;
         default: res_raddr = 14'($urandom);
      endcase
      step();
   endtask

   initial begin
      logic [13:0] last_addr;
      reset = 1'b0; img_we = 1'b0; img_waddr = '0; img_wdata = '0;
      img_load_done = 1'b0; gray_addr = '0; gray_req = 1'b0;
      lbp_addr = '0; lbp_valid = 1'b0; lbp_data = '0; finish = 1'b0;
      res_raddr = '0;
      step();
      check_en = 1'b1;
      checkOutput("rst_ready", {31'b0, gray_ready}, 32'h0);
      checkOutput("rst_rdata", {24'b0, res_rdata}, 32'h0);
      checkOutput("rst_wr", {17'b0, wr_count}, 32'h0);
      checkOutput("rst_done", {31'b0, done}, 32'h0);
      step();
      reset = 1'b1;

      // Load img[a] = a[7:0] with engine noise that LOAD must ignore;
      // the last write coincides with img_load_done
      for (int a = 0; a < 16384; a++) begin
         img_we        = 1'b1;
         img_waddr     = 14'(a);
         img_wdata     = 8'(a);
         img_load_done = (a == 16383);
         lbp_valid     = 1'($urandom);
         lbp_addr      = 14'($urandom);
         lbp_data      = 8'($urandom);
         finish        = 1'($urandom);
         gray_req      = 1'($urandom);
         gray_addr     = 14'($urandom);
         step();
      end
      img_we = 1'b0; img_load_done = 1'b0; lbp_valid = 1'b0; finish = 1'b0;
      gray_req = 1'b0;

      gray_addr = 14'h0081;
      #1;
      checkOutput("t1_ready", {31'b0, gray_ready}, 32'h1);
      checkOutput("t1_data", {24'b0, gray_data}, 32'h81);

      lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'hD6;
      step();
      lbp_addr = 14'h0000; lbp_data = 8'h3C;
      step();
      lbp_valid = 1'b0; res_raddr = 14'h0081;
      step();
      checkOutput("t2_rdata", {24'b0, res_rdata}, 32'hD6);
      checkOutput("t2_wr", {17'b0, wr_count}, 32'h2);

      last_addr = 14'h0081;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(last_addr);
         if (lbp_valid) last_addr = lbp_addr;
      end
      lbp_valid = 1'b0; gray_req = 1'b0; img_we = 1'b0;

      // Mid-SERVE reset, then serve the retained image again
      reset = 1'b0;
      step();
      reset = 1'b1;
      checkOutput("t5_ready", {31'b0, gray_ready}, 32'h0);
      checkOutput("t5_wr", {17'b0, wr_count}, 32'h0);
      checkOutput("t5_req", {17'b0, req_count}, 32'h0);
      img_load_done = 1'b1;
      step();
      img_load_done = 1'b0;
      gray_addr = 14'h3FFF;
      #1;
      checkOutput("t5_data_3fff", {24'b0, gray_data}, 32'hFF);
      gray_addr = 14'h1234;
      #1;
      checkOutput("t5_data_1234", {24'b0, gray_data}, 32'h34);

      // Interior sweep as the engine would produce it; finish arrives with
      // the last write
      for (int r = 1; r <= 126; r++) begin
         for (int c = 1; c <= 126; c++) begin
            lbp_valid = 1'b1;
            lbp_addr  = {r[6:0], c[6:0]};
            lbp_data  = 8'hFF;
            gray_req  = 1'($urandom);
            gray_addr = 14'($urandom);
            res_raddr = 14'($urandom);
            finish    = (r == 126) && (c == 126);
            step();
         end
      end
      lbp_valid = 1'b0; finish = 1'b0; gray_req = 1'b0;
      checkOutput("t3_done", {31'b0, done}, 32'h1);
      checkOutput("t3_wr", {17'b0, wr_count}, 32'd15876);
      checkOutput("t3_late", {31'b0, late_wr}, 32'h0);
      checkOutput("t3_ready", {31'b0, gray_ready}, 32'h0);

      lbp_valid = 1'b1; lbp_addr = 14'h0000; lbp_data = 8'h55;
      step();
      lbp_valid = 1'b0; res_raddr = 14'h0000;
      step();
      checkOutput("t4_late", {31'b0, late_wr}, 32'h1);
      checkOutput("t4_rdata", {24'b0, res_rdata}, 32'h3C);

      for (int i = 0; i < 200; i++) begin
         applyStimulus(14'h0081);
      end
      lbp_valid = 1'b0; img_we = 1'b0; gray_req = 1'b0;
      step();
      check_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
